// File: rtl/hazard_unit_mc.sv
// Hazard and forwarding control for a 5-stage pipeline with a multi-cycle MULDIV unit in EXE.
// Generates stall/flush/enable controls, forwarding selects and a saturating stall counter.
module hazard_unit_mc #(
  parameter int AW     = 5,
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cmu_stall,
  input  logic             Branch_ID,
  input  logic             rs1use_ID,
  input  logic             rs2use_ID,
  input  logic [2:0]       hazard_optype_ID,
  input  logic [AW-1:0]    rs1_ID,
  input  logic [AW-1:0]    rs2_ID,
  input  logic [AW-1:0]    rs2_EXE,
  input  logic [AW-1:0]    rd_EXE,
  input  logic [AW-1:0]    rd_MEM,
  output logic             PC_EN_IF,
  output logic             reg_FD_EN,
  output logic             reg_FD_stall,
  output logic             reg_FD_flush,
  output logic             reg_DE_EN,
  output logic             reg_DE_flush,
  output logic             reg_EM_EN,
  output logic             reg_EM_flush,
  output logic             reg_MW_EN,
  output logic [1:0]       forward_ctrl_A,
  output logic [1:0]       forward_ctrl_B,
  output logic             forward_ctrl_ls,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [2:0] {
    OP_NONE   = 3'd0,
    OP_ALU    = 3'd1,
    OP_LOAD   = 3'd2,
    OP_STORE  = 3'd3,
    OP_MULDIV = 3'd4
  } optype_e;

  // MULDIV holds EXE for MD_LAT cycles; MD_LAT=1 loads 0, so it never stalls.
  localparam logic [3:0] MD_INIT = 4'(MD_LAT - 1);

  optype_e          w_optype_id;
  optype_e          r_optype_exe;
  optype_e          r_optype_mem;
  logic [3:0]       r_md_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_ex_m1, w_ex_m2, w_mem_m1, w_mem_m2;
  logic w_exe_fwd_ok, w_mem_alu, w_mem_load;
  logic w_load_stall;

  assign w_optype_id = (hazard_optype_ID > 3'd4) ? OP_NONE : optype_e'(hazard_optype_ID);

  assign w_ex_m1  = rs1use_ID && (rs1_ID == rd_EXE) && (rd_EXE != '0);
  assign w_ex_m2  = rs2use_ID && (rs2_ID == rd_EXE) && (rd_EXE != '0);
  assign w_mem_m1 = rs1use_ID && (rs1_ID == rd_MEM) && (rd_MEM != '0);
  assign w_mem_m2 = rs2use_ID && (rs2_ID == rd_MEM) && (rd_MEM != '0);

  assign w_exe_fwd_ok = (r_optype_exe == OP_ALU) ||
                        ((r_optype_exe == OP_MULDIV) && (r_md_cnt == 4'd0));
  assign w_mem_alu    = (r_optype_mem == OP_ALU) || (r_optype_mem == OP_MULDIV);
  assign w_mem_load   = (r_optype_mem == OP_LOAD);

  function automatic logic [1:0] fwd_sel(input logic ex_m, input logic mem_m,
                                         input logic exe_ok, input logic mem_alu,
                                         input logic mem_load);
    if (ex_m && exe_ok)          return 2'd1;
    else if (mem_m && mem_alu)   return 2'd2;
    else if (mem_m && mem_load)  return 2'd3;
    else                         return 2'd0;
  endfunction

  assign forward_ctrl_A = fwd_sel(w_ex_m1, w_mem_m1, w_exe_fwd_ok, w_mem_alu, w_mem_load);
  assign forward_ctrl_B = fwd_sel(w_ex_m2, w_mem_m2, w_exe_fwd_ok, w_mem_alu, w_mem_load);

  // A STORE's rs2 is never stalled on a load; it is patched later from MEM load data.
  assign w_load_stall = (r_optype_exe == OP_LOAD) &&
                        (w_ex_m1 || (w_ex_m2 && (w_optype_id != OP_STORE)));

  assign forward_ctrl_ls = (r_optype_exe == OP_STORE) && (r_optype_mem == OP_LOAD) &&
                           (rs2_EXE == rd_MEM) && (rd_MEM != '0);

  assign md_busy   = (r_md_cnt != 4'd0);
  assign stall_cnt = r_stall_cnt;

  // NOTE: every output gets a default before the priority chain, so no path leaves one unassigned (no latches).
  always_comb begin
    PC_EN_IF     = 1'b1;
    reg_FD_EN    = 1'b1;
    reg_FD_stall = 1'b0;
    reg_FD_flush = 1'b0;
    reg_DE_EN    = 1'b1;
    reg_DE_flush = 1'b0;
    reg_EM_EN    = 1'b1;
    reg_EM_flush = 1'b0;
    reg_MW_EN    = 1'b1;
    if (cmu_stall) begin
      PC_EN_IF  = 1'b0;
      reg_FD_EN = 1'b0;
      reg_DE_EN = 1'b0;
      reg_EM_EN = 1'b0;
      reg_MW_EN = 1'b0;
    end else if (md_busy) begin
      PC_EN_IF     = 1'b0;
      reg_FD_EN    = 1'b0;
      reg_DE_EN    = 1'b0;
      reg_FD_stall = 1'b1;
      reg_EM_flush = 1'b1;
    end else if (w_load_stall) begin
      PC_EN_IF     = 1'b0;
      reg_FD_stall = 1'b1;
      reg_DE_flush = 1'b1;
    end else begin
      reg_FD_flush = Branch_ID;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_optype_exe <= OP_NONE;
      r_optype_mem <= OP_NONE;
      r_md_cnt     <= 4'd0;
      r_stall_cnt  <= '0;
    end else begin
      if (reg_DE_flush)   r_optype_exe <= OP_NONE;
      else if (reg_DE_EN) r_optype_exe <= w_optype_id;

      if (reg_EM_flush)   r_optype_mem <= OP_NONE;
      else if (reg_EM_EN) r_optype_mem <= r_optype_exe;

      if (reg_DE_EN && !reg_DE_flush && (w_optype_id == OP_MULDIV))
        r_md_cnt <= MD_INIT;
      else if ((r_md_cnt != 4'd0) && !cmu_stall)
        r_md_cnt <= r_md_cnt - 4'd1;

      if (!PC_EN_IF && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed-vector bench for hazard_unit_mc: load-use, store forwarding, MULDIV stall,
// cache-stall freeze, branch suppression, reset abort and stall counter saturation.
module tb_hazard_unit_mc;
  localparam int AW    = 5;
  localparam int CNT_W = 4;

  localparam logic [2:0] NONE = 3'd0, ALU = 3'd1, LOAD = 3'd2, STORE = 3'd3, MULDIV = 3'd4;

  // {PC_EN_IF, FD_EN, FD_stall, FD_flush, DE_EN, DE_flush, EM_EN, EM_flush, MW_EN}
  localparam logic [8:0] C_NORM   = 9'b1_1_0_0_1_0_1_0_1;
  localparam logic [8:0] C_BRANCH = 9'b1_1_0_1_1_0_1_0_1;
  localparam logic [8:0] C_LOAD   = 9'b0_1_1_0_1_1_1_0_1;
  localparam logic [8:0] C_MD     = 9'b0_0_1_0_0_0_1_1_1;
  localparam logic [8:0] C_CMU    = 9'b0_0_0_0_0_0_0_0_0;

  logic clk = 1'b0, rstn = 1'b0, cmu_stall = 1'b0, Branch_ID = 1'b0;
  logic rs1use_ID = 1'b0, rs2use_ID = 1'b0;
  logic [2:0] hazard_optype_ID = 3'd0;
  logic [AW-1:0] rs1_ID = '0, rs2_ID = '0, rs2_EXE = '0, rd_EXE = '0, rd_MEM = '0;
  logic PC_EN_IF, reg_FD_EN, reg_FD_stall, reg_FD_flush, reg_DE_EN, reg_DE_flush;
  logic reg_EM_EN, reg_EM_flush, reg_MW_EN, forward_ctrl_ls, md_busy;
  logic [1:0] forward_ctrl_A, forward_ctrl_B;
  logic [CNT_W-1:0] stall_cnt;
  logic [8:0] ctrl;

  int n_tests = 0;
  int n_fail  = 0;

  hazard_unit_mc #(.AW(AW), .MD_LAT(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn), .cmu_stall(cmu_stall), .Branch_ID(Branch_ID),
    .rs1use_ID(rs1use_ID), .rs2use_ID(rs2use_ID), .hazard_optype_ID(hazard_optype_ID),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rs2_EXE(rs2_EXE), .rd_EXE(rd_EXE), .rd_MEM(rd_MEM),
    .PC_EN_IF(PC_EN_IF), .reg_FD_EN(reg_FD_EN), .reg_FD_stall(reg_FD_stall),
    .reg_FD_flush(reg_FD_flush), .reg_DE_EN(reg_DE_EN), .reg_DE_flush(reg_DE_flush),
    .reg_EM_EN(reg_EM_EN), .reg_EM_flush(reg_EM_flush), .reg_MW_EN(reg_MW_EN),
    .forward_ctrl_A(forward_ctrl_A), .forward_ctrl_B(forward_ctrl_B),
    .forward_ctrl_ls(forward_ctrl_ls), .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  assign ctrl = {PC_EN_IF, reg_FD_EN, reg_FD_stall, reg_FD_flush, reg_DE_EN,
                 reg_DE_flush, reg_EM_EN, reg_EM_flush, reg_MW_EN};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic br, input logic [2:0] op, input logic u1,
                        input logic [AW-1:0] r1, input logic u2, input logic [AW-1:0] r2);
    Branch_ID = br; hazard_optype_ID = op;
    rs1use_ID = u1; rs1_ID = r1; rs2use_ID = u2; rs2_ID = r2;
  endtask

  task automatic set_pipe(input logic [AW-1:0] r2e, input logic [AW-1:0] rde,
                          input logic [AW-1:0] rdm);
    rs2_EXE = r2e; rd_EXE = rde; rd_MEM = rdm;
  endtask

  initial begin
    // Reset values
    #2;
    check("rst_ctrl", 32'(ctrl), 32'(C_NORM));
    check("rst_fwd", 32'({forward_ctrl_A, forward_ctrl_B, forward_ctrl_ls}), 32'd0);
    check("rst_busy", 32'(md_busy), 32'd0);
    check("rst_cnt", 32'(stall_cnt), 32'd0);
    @(negedge clk); rstn = 1'b1;
    tick();

    // Load-use stall on rs1, with a branch arriving during the stall
    set_id(0, LOAD, 0, 0, 0, 0); set_pipe(0, 0, 0); #1;
    check("lu_pre_ctrl", 32'(ctrl), 32'(C_NORM));
    tick();
    set_id(1, ALU, 1, 5, 0, 0); set_pipe(0, 5, 0); #1;
    check("lu_stall_ctrl", 32'(ctrl), 32'(C_LOAD));
    check("lu_stall_cnt0", 32'(stall_cnt), 32'd0);
    tick();
    set_pipe(0, 0, 5); #1;
    check("lu_fwdA_3", 32'(forward_ctrl_A), 32'd3);
    check("lu_cnt1", 32'(stall_cnt), 32'd1);
    check("br_after_stall", 32'(ctrl), 32'(C_BRANCH));
    tick();

    // EXE ALU forward, then STORE rs2 on a LOAD: no stall, later ls forward
    set_id(0, LOAD, 1, 9, 0, 0); set_pipe(0, 9, 0); #1;
    check("exe_fwdA_1", 32'(forward_ctrl_A), 32'd1);
    tick();
    set_id(0, STORE, 1, 6, 1, 5); set_pipe(0, 5, 6); #1;
    check("st_no_stall", 32'(ctrl), 32'(C_NORM));
    check("mem_alu_fwdA_2", 32'(forward_ctrl_A), 32'd2);
    check("st_fwdB_0", 32'(forward_ctrl_B), 32'd0);
    check("ls_idle", 32'(forward_ctrl_ls), 32'd0);
    tick();
    set_id(0, ALU, 1, 0, 0, 5); set_pipe(5, 0, 5); #1;
    check("ls_fwd", 32'(forward_ctrl_ls), 32'd1);
    check("x0_no_fwd", 32'(forward_ctrl_A), 32'd0);
    check("unused_rs2_no_fwd", 32'(forward_ctrl_B), 32'd0);
    tick();

    // MULDIV residency with a 2-cycle cache stall at md_cnt=2
    set_id(0, MULDIV, 0, 0, 0, 0); set_pipe(0, 0, 0); #1;
    check("md_issue_ctrl", 32'(ctrl), 32'(C_NORM));
    check("md_issue_busy", 32'(md_busy), 32'd0);
    tick();
    set_id(1, ALU, 1, 7, 0, 0); set_pipe(0, 7, 0); #1;
    check("md3_busy", 32'(md_busy), 32'd1);
    check("md3_ctrl", 32'(ctrl), 32'(C_MD));
    check("md3_no_fwd", 32'(forward_ctrl_A), 32'd0);
    tick();
    cmu_stall = 1'b1; #1;
    check("cmu1_ctrl", 32'(ctrl), 32'(C_CMU));
    check("cmu1_busy", 32'(md_busy), 32'd1);
    tick();
    check("cmu2_ctrl", 32'(ctrl), 32'(C_CMU));
    tick();
    cmu_stall = 1'b0; #1;
    check("md2_held_ctrl", 32'(ctrl), 32'(C_MD));
    tick();
    check("md1_ctrl", 32'(ctrl), 32'(C_MD));
    tick();
    Branch_ID = 1'b0; #1;
    check("md0_busy", 32'(md_busy), 32'd0);
    check("md0_fwdA_1", 32'(forward_ctrl_A), 32'd1);
    check("md0_ctrl", 32'(ctrl), 32'(C_NORM));
    check("md0_cnt", 32'(stall_cnt), 32'd6);
    tick();

    // MULDIV in MEM forwards 2; second MULDIV aborted by reset
    set_id(0, MULDIV, 1, 7, 0, 0); set_pipe(0, 0, 7); #1;
    check("mem_md_fwdA_2", 32'(forward_ctrl_A), 32'd2);
    tick();
    set_id(0, ALU, 1, 7, 0, 0); set_pipe(0, 7, 7); #1;
    check("md_b_busy", 32'(md_busy), 32'd1);
    tick();
    rstn = 1'b0; #1;
    check("rst_abort_busy", 32'(md_busy), 32'd0);
    check("rst_abort_cnt", 32'(stall_cnt), 32'd0);
    check("rst_abort_fwd", 32'({forward_ctrl_A, forward_ctrl_B}), 32'd0);
    check("rst_abort_ctrl", 32'(ctrl), 32'(C_NORM));
    @(negedge clk); rstn = 1'b1;
    tick();
    check("post_rst_busy", 32'(md_busy), 32'd0);
    tick();

    // Stall counter saturation (CNT_W=4)
    set_id(0, NONE, 0, 0, 0, 0); set_pipe(0, 0, 0);
    cmu_stall = 1'b1;
    repeat (17) tick();
    check("cnt_saturate", 32'(stall_cnt), 32'd15);
    cmu_stall = 1'b0;

    // EXE-over-MEM priority, MEM ALU forward on rs2, rs2 load stall, illegal optype
    set_id(0, LOAD, 0, 0, 0, 0); #1;
    tick();
    set_id(0, ALU, 0, 0, 0, 0); #1;
    tick();
    set_id(0, ALU, 0, 0, 1, 9); set_pipe(0, 9, 9); #1;
    check("exe_wins_fwdB_1", 32'(forward_ctrl_B), 32'd1);
    tick();
    set_id(0, LOAD, 1, 3, 1, 9); set_pipe(0, 3, 9); #1;
    check("mem_alu_fwdB_2", 32'(forward_ctrl_B), 32'd2);
    check("exe_fwdA_1b", 32'(forward_ctrl_A), 32'd1);
    tick();
    set_id(0, ALU, 0, 0, 1, 4); set_pipe(0, 4, 0); #1;
    check("rs2_load_stall", 32'(ctrl), 32'(C_LOAD));
    tick();
    set_id(0, 3'd6, 0, 0, 0, 0); set_pipe(0, 0, 0); #1;
    check("op6_ctrl", 32'(ctrl), 32'(C_NORM));
    tick();
    check("op6_not_md", 32'(md_busy), 32'd0);
    check("op6_ctrl_next", 32'(ctrl), 32'(C_NORM));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_unit_mc.md
HAZARD_UNIT_MC -- requirements
Module: hazard_unit_mc

Interface
REQ-001 Parameter AW, default 5, register-index width.
REQ-002 Parameter MD_LAT, default 4, EXE residency in cycles of a MULDIV op; legal range 1..15.
REQ-003 Parameter CNT_W, default 16, stall-counter width.
REQ-004 Port clk  input  1  sole clock, all state on the rising edge.
REQ-005 Port rstn  input  1  asynchronous, active-low reset.
REQ-006 Port cmu_stall  input  1  cache stall; freezes the whole pipeline.
REQ-007 Port Branch_ID  input  1  taken branch/jump resolved in ID.
REQ-008 Port rs1use_ID, rs2use_ID  input  1 each  ID reads rs1/rs2.
REQ-009 Port hazard_optype_ID  input  3  0 NONE, 1 ALU, 2 LOAD, 3 STORE, 4 MULDIV; 5-7 treated as NONE.
REQ-010 Port rs1_ID, rs2_ID, rs2_EXE, rd_EXE, rd_MEM  input  AW each  register indices.
REQ-011 Port PC_EN_IF, reg_FD_EN, reg_FD_stall, reg_FD_flush, reg_DE_EN, reg_DE_flush, reg_EM_EN, reg_EM_flush, reg_MW_EN  output  1 each  pipeline controls.
REQ-012 Port forward_ctrl_A, forward_ctrl_B  output  2 each  0 regfile, 1 EXE result, 2 MEM ALU result, 3 MEM load data.
REQ-013 Port forward_ctrl_ls  output  1  store data in EXE taken from MEM load data.
REQ-014 Port md_busy  output  1  MULDIV occupying EXE with cycles remaining.
REQ-015 Port stall_cnt  output  CNT_W  cycles with PC_EN_IF low, saturating.

Function
REQ-016 Registers optype_EXE/optype_MEM: EXE <= NONE if reg_DE_flush, else optype_ID if reg_DE_EN, else hold; MEM <= NONE if reg_EM_flush, else optype_EXE if reg_EM_EN, else hold.
REQ-017 Counter md_cnt (4 bits): loads MD_LAT-1 when reg_DE_EN & ~reg_DE_flush & optype_ID==MULDIV; else decrements when nonzero & ~cmu_stall; md_busy = (md_cnt!=0).
REQ-018 MD_LAT=1: md_cnt stays 0; MULDIV behaves as ALU.
REQ-019 Match terms require index equality, index nonzero, and corresponding rsNuse_ID.
REQ-020 EXE match forwards 1 when optype_EXE is ALU, or MULDIV with md_cnt==0.
REQ-021 MEM match forwards 2 when optype_MEM is ALU or MULDIV; 3 when LOAD; EXE match wins over MEM.
REQ-022 load_stall = EXE match with optype_EXE==LOAD on rs1, or on rs2 when optype_ID!=STORE; rs2 of a STORE is never stalled (covered by forward_ctrl_ls).
REQ-023 forward_ctrl_ls = optype_EXE==STORE & optype_MEM==LOAD & rs2_EXE==rd_MEM & rd_MEM!=0.
REQ-024 Priority cmu_stall > md_busy > load_stall.
REQ-025 cmu_stall=1: all *_EN=0, PC_EN_IF=0, all flush=0, reg_FD_stall=0; md_cnt, optype regs and forwarding selects held.
REQ-026 md_busy & ~cmu_stall: PC_EN_IF=0, reg_FD_EN=0, reg_DE_EN=0, reg_EM_EN=1, reg_EM_flush=1, reg_MW_EN=1, reg_FD_flush=0, reg_DE_flush=0, reg_FD_stall=1.
REQ-027 load_stall only: PC_EN_IF=0, reg_FD_stall=1, reg_DE_flush=1, reg_FD_flush=0, all *_EN=1.
REQ-028 No stall: all *_EN=1, PC_EN_IF=1, reg_FD_flush=Branch_ID, other flushes and reg_FD_stall 0.
REQ-029 Branch_ID is ignored (no FD flush) in any stalled cycle; ID re-presents it after the stall.
REQ-030 stall_cnt increments when PC_EN_IF=0; holds at 2^CNT_W-1.

Reset
REQ-031 rstn low asynchronously clears optype_EXE/MEM to NONE, md_cnt to 0, stall_cnt to 0; with cmu_stall=0, outputs are PC_EN_IF=1, all *_EN=1, flushes 0, forward selects 0, forward_ctrl_ls=0, md_busy=0.
REQ-032 Reset asserted during a MULDIV stall aborts it; first post-reset cycle md_busy=0.

Verification
REQ-033 LOAD x5 into EXE, ID ALU rs1=x5 -> one cycle PC_EN_IF=0, reg_DE_flush=1; next cycle forward_ctrl_A=3, stall_cnt=1.
REQ-034 LOAD x5 into EXE, ID STORE rs2=x5 rs1=x6 -> no stall; following cycle forward_ctrl_ls=1.
REQ-035 MD_LAT=4, MULDIV rd=x7 enters EXE, ID uses x7 -> md_busy high 3 cycles, reg_EM_flush=1 each; 4th cycle forward_ctrl_A=1, PC_EN_IF=1.
REQ-036 cmu_stall for 2 cycles mid-MULDIV (md_cnt=2) -> md_cnt holds at 2, all EN low, flushes 0; resumes countdown afterwards.
REQ-037 Branch_ID=1 during load_stall -> reg_FD_flush=0; next unstalled cycle reg_FD_flush=1.
REQ-038 rstn pulsed low with md_cnt=2 -> md_busy=0 immediately, stall_cnt=0, forward selects 0.
